// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 64;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; master = arbiter view.
interface mem_arbiter_if #(
    parameter int AW = mem_arb_pkg::AW_DEF,
    parameter int DW = mem_arb_pkg::DW_DEF
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          done0;
    logic          done1;
    logic          err;
    logic [DW-1:0] rdata;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_r_addr;
    logic [AW-1:0] mem_w_addr;
    logic [DW-1:0] mem_d_in;
    logic [DW-1:0] mem_d_out;
    logic          mem_r_finished;
    logic          mem_w_finished;

    modport master (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  mem_d_out, mem_r_finished, mem_w_finished,
        output done0, done1, err, rdata,
        output mem_re, mem_we, mem_r_addr, mem_w_addr, mem_d_in
    );

    modport slave (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output mem_d_out, mem_r_finished, mem_w_finished,
        input  done0, done1, err, rdata,
        input  mem_re, mem_we, mem_r_addr, mem_w_addr, mem_d_in
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin: on a tie the port other than last_i wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       gnt_o
);

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            gnt_o = ~last_i;
        end else begin
            gnt_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (port 0) and data (port 1),
// with registered memory controls, edge-qualified completion and a timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          mwe_q, mwe_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;

    logic arb_valid, arb_gnt, fin;

    rr_arb2 u_arb (
        .req_i   ({bus.req1, bus.req0}),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        re_d    = re_q;
        mwe_d   = mwe_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        fin     = we_q ? bus.mem_w_finished : bus.mem_r_finished;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    last_d  = arb_gnt;
                    we_d    = arb_gnt ? bus.we1 : bus.we0;
                    state_d = ISSUE;
                    if (we_d) begin
                        waddr_d = arb_gnt ? bus.addr1 : bus.addr0;
                        din_d   = arb_gnt ? bus.wdata1 : bus.wdata0;
                        mwe_d   = 1'b1;
                    end else begin
                        raddr_d = arb_gnt ? bus.addr1 : bus.addr0;
                        re_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                seen_d  = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A 1 only counts once a 0 was seen, so a stale level can't complete.
                if (fin && seen_q) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_d_out;
                    end
                    re_d    = 1'b0;
                    mwe_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    re_d    = 1'b0;
                    mwe_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    if (!fin) begin
                        seen_d = 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            mwe_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            re_q    <= re_d;
            mwe_q   <= mwe_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.done0      = (state_q == DONE) && (gnt_q == PORT_IF);
    assign bus.done1      = (state_q == DONE) && (gnt_q == PORT_D);
    assign bus.err        = (state_q == DONE) && err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_re     = re_q;
    assign bus.mem_we     = mwe_q;
    assign bus.mem_r_addr = raddr_q;
    assign bus.mem_w_addr = waddr_q;
    assign bus.mem_d_in   = din_q;

endmodule
